sram_like_mem_slave: RTL and testbench

SRAM_LIKE_MEM_SLAVE -- requirements
Module: sram_like_mem_slave

---
 rtl/sram_like_mem_slave.sv | 109 ++++++++++
 tb/tb_sram_like_mem_slave.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_mem_slave.sv
// SRAM-like memory slave: in-order pending queue with a fixed minimum response
// latency; memory writes and reads take effect when a request retires.
module sram_like_mem_slave #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        stall
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(LATENCY + 1);

    logic [DEPTH-1:0]  q_wr;
    logic [ADDR_W-1:0] q_idx   [DEPTH];
    logic [31:0]       q_wdata [DEPTH];
    logic [3:0]        q_wstrb [DEPTH];
    logic [AW-1:0]     q_age   [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              retire;
    logic              head_eligible;
    logic [ADDR_W-1:0] req_idx;

    // Size, byte offset and high address bits never affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        req_idx       = addr[ADDR_W+1:2];
        addr_ok       = !reset && (count < CW'(DEPTH));
        accept        = req && addr_ok;
        head_eligible = q_age[head] >= AW'(LATENCY - 1);
        data_ok       = !reset && (count != '0) && head_eligible && !stall;
        retire        = data_ok;
        rdata         = '0;
        if (data_ok && !q_wr[head]) begin
            rdata = mem[q_idx[head]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_age[i] <= '0;
            end
        end else begin
            if (retire) begin
                head <= ptr_inc(head);
            end
            if (accept) begin
                tail           <= ptr_inc(tail);
                q_wr[tail]     <= wr;
                q_idx[tail]    <= req_idx;
                q_wdata[tail]  <= wdata;
                q_wstrb[tail]  <= wstrb;
            end
            case ({accept, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Ages run regardless of stall and saturate; a fresh entry restarts at zero.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (accept && (tail == PW'(i))) begin
                    q_age[i] <= '0;
                end else if (q_age[i] < AW'(LATENCY)) begin
                    q_age[i] <= q_age[i] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (retire && q_wr[head]) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (q_wstrb[head][b]) begin
                    mem[q_idx[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: timestamped request queue plus reference
// memory predicts every output each cycle; directed cases pin literal values.
module tb_sram_like_mem_slave;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  size  = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    sram_like_mem_slave #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        int          idx;
        logic [31:0] d;
        logic [3:0]  s;
        int          stamp;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [2**ADDR_W];
    int          mcyc    = 0;
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          dut_acc = 0;
    int          dut_dok = 0;
    int          mdl_acc = 0;
    int          resp_cyc[$];
    logic [31:0] resp_data[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, mcyc);
        end
    endfunction

    function automatic logic [31:0] pre_val(input int i);
        return {8'hC0 + 8'(i), 8'h5A, 8'(i), 8'h3C};
    endfunction

    // A request accepted at the edge closing cycle c carries stamp c+1 and is
    // due once LATENCY-1 cycles have passed since then.
    always @(negedge clk) begin
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;
        ent_t        h;
        ent_t        n;
        e_aok = !reset && (q.size() < int'(DEPTH));
        e_dok = 1'b0;
        e_rd  = '0;
        if (!reset && q.size() > 0 && !stall && (mcyc - q[0].stamp >= int'(LATENCY) - 1))
            e_dok = 1'b1;
        if (e_dok && !q[0].w)
            e_rd = mem_m[q[0].idx];
        check("addr_ok", 32'(addr_ok), 32'(e_aok));
        check("data_ok", 32'(data_ok), 32'(e_dok));
        check("rdata",   rdata,        e_rd);
        if (data_ok) dut_dok++;
        if (req && addr_ok) dut_acc++;
        if (e_dok) begin
            resp_cyc.push_back(mcyc);
            resp_data.push_back(rdata);
        end
        if (reset) begin
            q.delete();
        end else begin
            if (e_dok) begin
                h = q.pop_front();
                if (h.w)
                    for (int b = 0; b < 4; b++)
                        if (h.s[b]) mem_m[h.idx][8*b +: 8] = h.d[8*b +: 8];
            end
            if (req && e_aok) begin
                n.w     = wr;
                n.idx   = int'(addr[ADDR_W+1:2]);
                n.d     = wdata;
                n.s     = wstrb;
                n.stamp = mcyc + 1;
                q.push_back(n);
                mdl_acc++;
            end
        end
        mcyc++;
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 1'b0;
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 3'd2;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = addr_ok;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: addr %h not accepted, required acceptance", a);
        end
    endtask

    task automatic drain();
        int t = 0;
        req   = 1'b0;
        stall = 1'b0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d pending, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_resp();
        resp_cyc.delete();
        resp_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int acc_local;
        int a0;
        int d0;
        int m0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_addr_ok_low", 32'(addr_ok), 32'd0);
        reset = 1'b0;

        // Preload words 0..15; the first request goes in the first cycle out of reset.
        c0 = mcyc;
        issue(1'b1, 32'h0, pre_val(0), 4'hF);
        check("first_accept_cycles", 32'(mcyc - c0), 32'd1);
        for (int i = 1; i < 16; i++) issue(1'b1, 32'(i * 4), pre_val(i), 4'hF);
        drain();

        // Write then read of the same word, back to back.
        clear_resp();
        c0 = mcyc;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        drain();
        check("a_resp_count", 32'(resp_cyc.size()), 32'd2);
        if (resp_cyc.size() == 2) begin
            check("a_write_latency", 32'(resp_cyc[0] - c0), 32'd2);
            check("a_read_latency",  32'(resp_cyc[1] - c0), 32'd3);
            check("a_write_rdata",   resp_data[0], 32'h0);
            check("a_read_data",     resp_data[1], 32'hDEADBEEF);
        end

        // Single-byte write merged into an existing word.
        clear_resp();
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        issue(1'b1, 32'h21, 32'h0000AB00, 4'b0010);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        drain();
        check("b_resp_count", 32'(resp_data.size()), 32'd3);
        if (resp_data.size() == 3) check("b_merged_word", resp_data[2], 32'h1122AB44);

        // Stalled traffic fills the queue, then drains in order back to back.
        clear_resp();
        stall     = 1'b1;
        acc_local = 0;
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wr = 1'b0; addr = 32'(i * 4); wstrb = '0;
            @(negedge clk);
            if (addr_ok) acc_local++;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        check("c_accepts", 32'(acc_local), 32'd4);
        check("c_no_resp_while_stalled", 32'(resp_cyc.size()), 32'd0);
        check("c_addr_ok_when_full", 32'(addr_ok), 32'd0);
        stall = 1'b0;
        c0    = mcyc;
        drain();
        check("c_resp_count", 32'(resp_cyc.size()), 32'd4);
        if (resp_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("c_order_data", resp_data[k], pre_val(k));
                check("c_resp_cycle", 32'(resp_cyc[k] - c0), 32'(k));
            end
        end

        // Full queue retiring in the same cycle still refuses a new request.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
        stall = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h18; wstrb = '0;
        @(negedge clk);
        check("d_full_addr_ok", 32'(addr_ok), 32'd0);
        check("d_full_data_ok", 32'(data_ok), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("d_next_addr_ok", 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        drain();

        // Reset with a write and a read outstanding discards both.
        clear_resp();
        issue(1'b1, 32'h14, 32'hBAD0BAD0, 4'hF);
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        check("e_reset_data_ok", 32'(data_ok), 32'd0);
        check("e_reset_rdata",   rdata,        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("e_no_resp_after_reset", 32'(resp_cyc.size()), 32'd0);
        c0 = mcyc;
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        drain();
        check("e_resp_count", 32'(resp_cyc.size()), 32'd1);
        if (resp_cyc.size() == 1) begin
            check("e_latency",  32'(resp_cyc[0] - c0), 32'(LATENCY));
            check("e_old_word", resp_data[0], pre_val(5));
        end

        // Random traffic over aliased addresses of the preloaded words.
        a0 = dut_acc;
        d0 = dut_dok;
        m0 = mdl_acc;
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 9) < 6);
            wr    = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 4) == 0);
            size  = 3'($urandom_range(0, 7));
            wstrb = 4'($urandom);
            wdata = $urandom;
            addr  = {18'($urandom), 12'($urandom_range(0, 15)), 2'($urandom)};
            @(posedge clk);
            #1;
        end
        drain();
        check("f_dok_equals_accepts", 32'(dut_dok - d0), 32'(dut_acc - a0));
        check("f_accepts_vs_model",   32'(dut_acc - a0), 32'(mdl_acc - m0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
